ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
// - RV32M multiply/divide unit inside the EX stage; consumes aluop/reg1/reg2 from id_ex.
// - MUL* complete in one registered cycle; DIV*/REM* use an iterative radix-2 restoring divider.
// - Requests a pipeline stall from ctrl until the result is ready; the result is muxed into EX writeback.
// PARAMETERS
// - XLEN  32  operand/result width; divider iteration count = XLEN
// PORTS
// - clk         in   1        clock
// - rst         in   1        reset, asynchronous, active-low
// - start_i     in   1        EX holds an M-extension op (aluop in EXE_MUL..EXE_REMU)
// - aluop_i     in   AluOpBus op code, held stable while stall_req_o=1
// - op1_i       in   XLEN     rs1 value (dividend / multiplicand)
// - op2_i       in   XLEN     rs2 value (divisor / multiplier)
// - flush_i     in   1        flush[3]; abort current op
// - hold_i      in   1        stalled[4]; downstream stall, keep result
// - result_o    out  XLEN     result, valid while ready_o=1
// - ready_o     out  1        result valid this cycle
// - busy_o      out  1        FSM not IDLE
// - stall_req_o out  1        stall request to ctrl (combinational)
// BEHAVIOUR
// - Reset: state=IDLE, result_o=0, ready_o=0, busy_o=0, counter=0, operand/partial regs=0.
// - States: IDLE, DIV_BUSY, DONE.
// - stall_req_o = start_i & ~ready_o & ~flush_i.
// - IDLE, start_i=1: MUL/MULH/MULHSU/MULHU: XLEN x XLEN -> 2*XLEN product computed
//   (signedness per op), low or high half stored in result reg, ->DONE. 1 stall cycle.
// - IDLE, DIV*/REM*, op2=0: DIV/DIVU=all-ones, REM/REMU=op1; ->DONE. 1 stall cycle.
// - IDLE, DIV/REM, op1=0x80000000, op2=all-ones: DIV=0x80000000, REM=0; ->DONE.
// - Otherwise: latch |op1|,|op2| (signed ops) and quotient/remainder sign flags,
//   counter=0, ->DIV_BUSY.
// - DIV_BUSY: per cycle shift remainder:dividend left 1, trial-subtract divisor, set quotient bit
//   if non-negative; counter++; after XLEN iterations apply sign fix
//   (quotient negated if operand signs differ; remainder takes dividend sign), ->DONE.
//   Start to ready: XLEN+1 stall cycles.
// - DONE: ready_o=1, result_o driven; stall_req_o=0 so id_ex/ex advance next edge.
//   hold_i=1 -> stay DONE, result stable; hold_i=0 -> IDLE.
// - No new op is accepted in the cycle after DONE unless start_i is still high with a new instruction
//   (pipeline advanced); back-to-back M ops supported with no bubble beyond stall cycles.
// - flush_i=1 in any state: ->IDLE next edge, ready_o=0, result discarded, no writeback;
//   has priority over start_i and hold_i.
// - start_i=0 while in DIV_BUSY (instruction killed without flush): ->IDLE, abort.
// - Operands/aluop change while busy: protocol violation, not checked.
// - Async reset mid-division: immediate IDLE, all outputs per reset values.
// - Arithmetic: all subtracts XLEN+1 bits wide; negation two's complement; no X on result_o when ready_o=0
//   (holds last value).
// STRUCTURE
// - yadan_defs.v: EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU, EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU
//   codes; state encodings MD_IDLE/MD_DIV_BUSY/MD_DONE.
// - Sub-module div_core: unsigned iterative restoring divider (start, dividend, divisor ->
//   quotient, remainder, done); ex_muldiv owns sign handling, special cases, multiply and FSM.
// TESTING
// - MUL 7 x -3 -> result 0xFFFFFFEB, ready_o 1 cycle after start, stall_req_o high exactly 1 cycle.
// - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
// - DIV -20/3 -> 0xFFFFFFFA, REM -20/3 -> 0xFFFFFFFE; stall_req_o high XLEN+1=33 cycles.
// - DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; 1 stall cycle each.
// - flush_i at iteration 10 of DIV -> IDLE next cycle, ready_o never asserted; following MUL 3x4 -> 12.
// - rst low at iteration 20 -> all outputs 0, busy_o 0; hold_i=1 in DONE for 3 cycles -> result stable,
//   ready_o stays 1, then IDLE.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: ALU op codes
// for the M extension and the unit's FSM state encoding.
package ex_muldiv_pkg;

    localparam int unsigned ALUOP_W = 8;

    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t EXE_MUL    = 8'h30;
    localparam aluop_t EXE_MULH   = 8'h31;
    localparam aluop_t EXE_MULHSU = 8'h32;
    localparam aluop_t EXE_MULHU  = 8'h33;
    localparam aluop_t EXE_DIV    = 8'h34;
    localparam aluop_t EXE_DIVU   = 8'h35;
    localparam aluop_t EXE_REM    = 8'h36;
    localparam aluop_t EXE_REMU   = 8'h37;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_DIV_BUSY = 2'd1,
        MD_DONE     = 2'd2
    } md_state_e;

    // True for DIV/REM, which interpret their operands as signed.
    function automatic logic is_signed_div(input aluop_t op);
        return (op == EXE_DIV) || (op == EXE_REM);
    endfunction

    // True for REM/REMU, which return the remainder rather than the quotient.
    function automatic logic is_rem(input aluop_t op);
        return (op == EXE_REM) || (op == EXE_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Unsigned iterative radix-2 restoring divider, one quotient bit per cycle.
// done_o rises during the final iteration; quotient_o/remainder_o then carry
// the values being written on that edge so the caller can capture them
// without an extra cycle.
module ex_muldiv_div_core
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             last_iter;

    // One restoring step: shift remainder:dividend left, trial-subtract divisor.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    assign last_iter = busy_q && (cnt_q == CNT_W'(XLEN - 1));

    // Next-state for the divider registers.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;
    assign done_o      = last_iter && !abort_i && !start_i;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage. Multiplies finish in one
// registered cycle; divides/remainders run on the iterative divider core.
// Stalls the pipeline until the result is ready.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic               flush_i,
    input  logic               hold_i,
    output logic [XLEN-1:0]    result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               stall_req_o
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            sel_rem_q, sel_rem_d;

    logic            div_start;
    logic            div_abort;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic [XLEN-1:0] div_quotient;
    logic [XLEN-1:0] div_remainder;
    logic            div_done;

    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic              op1_neg;
    logic              op2_neg;
    logic              sdiv;

    // Operands extended to 2*XLEN per op signedness; the truncated product is
    // exact modulo 2^(2*XLEN), which is all that the low/high halves need.
    always_comb begin
        mul_a = {{XLEN{1'b0}}, op1_i};
        mul_b = {{XLEN{1'b0}}, op2_i};
        if (aluop_i == EXE_MULH || aluop_i == EXE_MULHSU) begin
            mul_a = {{XLEN{op1_i[XLEN-1]}}, op1_i};
        end
        if (aluop_i == EXE_MULH) begin
            mul_b = {{XLEN{op2_i[XLEN-1]}}, op2_i};
        end
        mul_prod = mul_a * mul_b;
    end

    // Magnitudes and sign flags for signed division.
    always_comb begin
        sdiv         = is_signed_div(aluop_i);
        op1_neg      = sdiv && op1_i[XLEN-1];
        op2_neg      = sdiv && op2_i[XLEN-1];
        div_dividend = op1_neg ? (~op1_i + 1'b1) : op1_i;
        div_divisor  = op2_neg ? (~op2_i + 1'b1) : op2_i;
    end

    ex_muldiv_div_core #(
        .XLEN(XLEN)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quotient),
        .remainder_o(div_remainder),
        .done_o     (div_done)
    );

    // FSM next-state, result capture and divider control.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (flush_i) begin
            state_d   = MD_IDLE;
            div_abort = 1'b1;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        case (aluop_i)
                            EXE_MUL: begin
                                result_d = mul_prod[XLEN-1:0];
                                state_d  = MD_DONE;
                            end
                            EXE_MULH, EXE_MULHSU, EXE_MULHU: begin
                                result_d = mul_prod[2*XLEN-1:XLEN];
                                state_d  = MD_DONE;
                            end
                            EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU: begin
                                if (op2_i == '0) begin
                                    result_d = is_rem(aluop_i) ? op1_i : '1;
                                    state_d  = MD_DONE;
                                end else if (sdiv && op1_i == MOST_NEG && op2_i == '1) begin
                                    result_d = is_rem(aluop_i) ? '0 : MOST_NEG;
                                    state_d  = MD_DONE;
                                end else begin
                                    neg_quo_d = op1_neg ^ op2_neg;
                                    neg_rem_d = op1_neg;
                                    sel_rem_d = is_rem(aluop_i);
                                    div_start = 1'b1;
                                    state_d   = MD_DIV_BUSY;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MD_DIV_BUSY: begin
                    if (!start_i) begin
                        state_d   = MD_IDLE;
                        div_abort = 1'b1;
                    end else if (div_done) begin
                        if (sel_rem_q) begin
                            result_d = neg_rem_q ? (~div_remainder + 1'b1) : div_remainder;
                        end else begin
                            result_d = neg_quo_q ? (~div_quotient + 1'b1) : div_quotient;
                        end
                        state_d = MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!hold_i) begin
                        state_d = MD_IDLE;
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    assign result_o    = result_q;
    assign ready_o     = (state_q == MD_DONE);
    assign busy_o      = (state_q != MD_IDLE);
    assign stall_req_o = start_i & ~ready_o & ~flush_i;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic [ALUOP_W-1:0] aluop_i;
    logic [XLEN-1:0]    op1_i;
    logic [XLEN-1:0]    op2_i;
    logic               flush_i;
    logic               hold_i;
    logic [XLEN-1:0]    result_o;
    logic               ready_o;
    logic               busy_o;
    logic               stall_req_o;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .aluop_i    (aluop_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .flush_i    (flush_i),
        .hold_i     (hold_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .stall_req_o(stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at posedge+1 in IDLE; wait (bounded) for ready_o, then drop
    // start_i and let the unit return to IDLE.
    task automatic issue(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int stalls, output logic ok);
        aluop_i = op; op1_i = a; op2_i = b; start_i = 1'b1;
        stalls = 0; ok = 1'b0; res = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ready_o) begin
                ok  = 1'b1;
                res = result_o;
                break;
            end
            if (stall_req_o) stalls++;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] res;
    logic [31:0] held;
    int          stalls;
    logic        ok;

    initial begin
        rst = 1'b0; start_i = 1'b0; aluop_i = '0; op1_i = '0; op2_i = '0;
        flush_i = 1'b0; hold_i = 1'b0;
        #12;
        chk("reset result", result_o, 32'h0);
        chk("reset ready", {31'b0, ready_o}, 32'd0);
        chk("reset busy", {31'b0, busy_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // MUL 7 x -3 with cycle-exact timing
        aluop_i = EXE_MUL; op1_i = 32'd7; op2_i = 32'hFFFF_FFFD; start_i = 1'b1;
        #1;
        chk("mul stall cyc0", {31'b0, stall_req_o}, 32'd1);
        chk("mul ready cyc0", {31'b0, ready_o}, 32'd0);
        @(posedge clk); #1;
        chk("mul ready cyc1", {31'b0, ready_o}, 32'd1);
        chk("mul stall cyc1", {31'b0, stall_req_o}, 32'd0);
        chk("mul result", result_o, 32'hFFFF_FFEB);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("mul idle after", {30'b0, busy_o, ready_o}, 32'd0);

        issue(EXE_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, stalls, ok);
        chk("mulhu ok", {31'b0, ok}, 32'd1);
        chk("mulhu result", res, 32'hFFFF_FFFE);
        issue(EXE_MULHSU, 32'hFFFF_FFFF, 32'd2, res, stalls, ok);
        chk("mulhsu result", res, 32'hFFFF_FFFF);
        issue(EXE_MULH, 32'hFFFF_FFFF, 32'd2, res, stalls, ok);
        chk("mulh result", res, 32'hFFFF_FFFF);

        issue(EXE_DIV, 32'hFFFF_FFEC, 32'd3, res, stalls, ok);
        chk("div ok", {31'b0, ok}, 32'd1);
        chk("div result", res, 32'hFFFF_FFFA);
        chk("div stalls", stalls, 32'd33);
        issue(EXE_REM, 32'hFFFF_FFEC, 32'd3, res, stalls, ok);
        chk("rem result", res, 32'hFFFF_FFFE);
        chk("rem stalls", stalls, 32'd33);
        issue(EXE_DIVU, 32'd100, 32'd7, res, stalls, ok);
        chk("divu result", res, 32'd14);
        issue(EXE_REMU, 32'd100, 32'd7, res, stalls, ok);
        chk("remu result", res, 32'd2);
        issue(EXE_DIV, 32'd20, 32'hFFFF_FFFD, res, stalls, ok);
        chk("div pos/neg", res, 32'hFFFF_FFFA);
        issue(EXE_REM, 32'd20, 32'hFFFF_FFFD, res, stalls, ok);
        chk("rem pos/neg", res, 32'd2);

        issue(EXE_DIVU, 32'd5, 32'd0, res, stalls, ok);
        chk("divu by0", res, 32'hFFFF_FFFF);
        chk("divu by0 stalls", stalls, 32'd1);
        issue(EXE_REMU, 32'd5, 32'd0, res, stalls, ok);
        chk("remu by0", res, 32'd5);
        chk("remu by0 stalls", stalls, 32'd1);
        issue(EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, stalls, ok);
        chk("div ovf", res, 32'h8000_0000);
        chk("div ovf stalls", stalls, 32'd1);
        issue(EXE_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, stalls, ok);
        chk("rem ovf", res, 32'h0);
        chk("rem ovf stalls", stalls, 32'd1);

        // Flush at iteration 10 of a DIV
        aluop_i = EXE_DIV; op1_i = 32'd1000; op2_i = 32'd7; start_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
        end
        chk("flush pre busy", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush busy", {31'b0, busy_o}, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) ok = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush no ready", {31'b0, ok}, 32'd0);
        issue(EXE_MUL, 32'd3, 32'd4, res, stalls, ok);
        chk("mul after flush", res, 32'd12);

        // Async reset at iteration 20 of a DIV
        aluop_i = EXE_DIVU; op1_i = 32'd1000; op2_i = 32'd7; start_i = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
        end
        chk("rst pre busy", {31'b0, busy_o}, 32'd1);
        #2 rst = 1'b0; start_i = 1'b0;
        #1;
        chk("rst result", result_o, 32'h0);
        chk("rst flags", {29'b0, busy_o, ready_o, stall_req_o}, 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Hold in DONE for 3 cycles
        hold_i = 1'b1;
        aluop_i = EXE_MUL; op1_i = 32'd6; op2_i = 32'd9; start_i = 1'b1;
        @(posedge clk); #1;
        held = result_o;
        chk("hold result", held, 32'd54);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold ready", {31'b0, ready_o}, 32'd1);
            chk("hold stable", result_o, 32'd54);
        end
        hold_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        chk("hold release", {30'b0, busy_o, ready_o}, 32'd0);
        chk("hold keeps value", result_o, 32'd54);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
